mem_arbiter: RTL and testbench

Sequencer and arbiter for the single byte-wide RAM port. It serves three requesters: the load/store unit (1/2/4-byte read or write) and two instruction-fetch ports X and Y (4-byte reads). Each granted request is serialized into byte transfers, and the result is returned as a little-endian word. The block sits between the instruction/data caches and the memory bus and owns `mem_a`, `mem_dout` and `mem_wr` exclusively.

---
 rtl/mem_arbiter_pkg.sv | 40 ++++
 rtl/mem_arb_pick.sv | 35 +++
 rtl/mem_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter shared types: state and requester encodings, byte helpers.
// Imported by the picker and the sequencer top.
package mem_arbiter_pkg;

    localparam int AW = 32;

    typedef logic [AW-1:0] addr_t;
    typedef logic [31:0]   word_t;
    typedef logic [7:0]    byte_t;

    localparam logic READ_SIGNAL  = 1'b0;
    localparam logic WRITE_SIGNAL = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        LS  = 2'd0,
        IFX = 2'd1,
        IFY = 2'd2
    } req_id_t;

    // Index of the last byte: 1 -> 0, 2 -> 1, anything else -> 3.
    function automatic logic [2:0] size_to_last(input logic [2:0] size);
        logic [2:0] last;
        last = 3'd3;
        if (size == 3'd1) last = 3'd0;
        if (size == 3'd2) last = 3'd1;
        return last;
    endfunction

    function automatic byte_t get_byte(input word_t w, input logic [1:0] i);
        return w[{i, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational requester picker: load/store first, then round-robin X/Y.
// Ports: three reqs, pref_y (1 = Y favoured), flush -> id, valid.
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic    ls_req,
    input  logic    ifx_req,
    input  logic    ify_req,
    input  logic    pref_y,
    input  logic    flush,
    output req_id_t id,
    output logic    valid
);

    logic fx, fy, g_ls, g_x, g_y;

    // A fetch seen on a flush edge is stale and must not be granted.
    assign fx   = ifx_req & ~flush;
    assign fy   = ify_req & ~flush;
    assign g_ls = ls_req;
    assign g_x  = ~ls_req & fx & (~fy | ~pref_y);
    assign g_y  = ~ls_req & fy & (~fx | pref_y);

    always_comb begin
        id    = LS;
        valid = 1'b0;
        unique case (1'b1)
            g_ls: begin id = LS;  valid = 1'b1; end
            g_x:  begin id = IFX; valid = 1'b1; end
            g_y:  begin id = IFY; valid = 1'b1; end
            default: begin id = LS; valid = 1'b0; end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Byte-wide RAM port sequencer serving load/store and two fetch ports.
// Ports: clk/rst/rdy, ls_*, ifx_*, ify_*, flush, mem_* bus, busy.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [2:0]            ls_size,
    input  logic [31:0]           ls_wdata,
    output logic                  ls_done,
    output logic [31:0]           ls_rdata,
    input  logic                  ifx_req,
    input  logic [ADDR_WIDTH-1:0] ifx_addr,
    output logic                  ifx_done,
    output logic [31:0]           ifx_inst,
    input  logic                  ify_req,
    input  logic [ADDR_WIDTH-1:0] ify_addr,
    output logic                  ify_done,
    output logic [31:0]           ify_inst,
    input  logic                  flush,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    output logic                  busy
);

    state_t                state;
    req_id_t               cur_id;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [2:0]            cur_last;
    word_t                 cur_wdata;
    word_t                 data_q;
    word_t                 rd_word;
    logic [2:0]            cnt;
    logic [2:0]            cnt_nx;
    logic [ADDR_WIDTH-1:0] addr_nx;
    logic                  kill;
    logic                  pref_y;
    req_id_t               pick_id;
    logic                  pick_vld;

    mem_arb_pick u_pick (
        .ls_req  (ls_req),
        .ifx_req (ifx_req),
        .ify_req (ify_req),
        .pref_y  (pref_y),
        .flush   (flush),
        .id      (pick_id),
        .valid   (pick_vld)
    );

    assign busy    = (state != IDLE);
    assign cnt_nx  = cnt + 3'd1;
    assign addr_nx = cur_addr + {{(ADDR_WIDTH-3){1'b0}}, cnt_nx};

    // Captured word including the byte arriving on this edge.
    always_comb begin
        rd_word = data_q;
        unique case (cnt[1:0])
            2'd0: rd_word[7:0]   = mem_din;
            2'd1: rd_word[15:8]  = mem_din;
            2'd2: rd_word[23:16] = mem_din;
            2'd3: rd_word[31:24] = mem_din;
            default: rd_word = data_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cur_id    <= LS;
            cur_addr  <= '0;
            cur_last  <= '0;
            cur_wdata <= '0;
            data_q    <= '0;
            cnt       <= '0;
            kill      <= 1'b0;
            pref_y    <= 1'b0;
            ls_done   <= 1'b0;
            ls_rdata  <= '0;
            ifx_done  <= 1'b0;
            ifx_inst  <= '0;
            ify_done  <= 1'b0;
            ify_inst  <= '0;
            mem_dout  <= '0;
            mem_a     <= '0;
            mem_wr    <= 1'b0;
        end else if (rdy) begin
            unique case (state)
                IDLE: begin
                    if (pick_vld) begin
                        cur_id <= pick_id;
                        cnt    <= '0;
                        data_q <= '0;
                        kill   <= 1'b0;
                        state  <= RD;
                        unique case (pick_id)
                            LS: begin
                                cur_addr  <= ls_addr;
                                cur_last  <= size_to_last(ls_size);
                                cur_wdata <= ls_wdata;
                                mem_a     <= ls_addr;
                                if (ls_we == WRITE_SIGNAL) begin
                                    state    <= WR;
                                    mem_wr   <= 1'b1;
                                    mem_dout <= ls_wdata[7:0];
                                end
                            end
                            IFX: begin
                                cur_addr <= ifx_addr;
                                cur_last <= 3'd3;
                                mem_a    <= ifx_addr;
                                pref_y   <= 1'b1;
                            end
                            IFY: begin
                                cur_addr <= ify_addr;
                                cur_last <= 3'd3;
                                mem_a    <= ify_addr;
                                pref_y   <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                RD: begin
                    data_q <= rd_word;
                    if (flush && cur_id != LS) kill <= 1'b1;
                    if (cnt == cur_last) begin
                        state <= DONE;
                        mem_a <= '0;
                        unique case (cur_id)
                            LS: begin
                                ls_done  <= 1'b1;
                                ls_rdata <= rd_word;
                            end
                            IFX: begin
                                ifx_done <= ~(kill | flush);
                                ifx_inst <= rd_word;
                            end
                            IFY: begin
                                ify_done <= ~(kill | flush);
                                ify_inst <= rd_word;
                            end
                            default: ;
                        endcase
                    end else begin
                        cnt   <= cnt_nx;
                        mem_a <= addr_nx;
                    end
                end
                WR: begin
                    if (cnt == cur_last) begin
                        state   <= DONE;
                        mem_wr  <= 1'b0;
                        mem_a   <= '0;
                        ls_done <= 1'b1;
                    end else begin
                        cnt      <= cnt_nx;
                        mem_a    <= addr_nx;
                        mem_dout <= get_byte(cur_wdata, cnt_nx[1:0]);
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    ls_done  <= 1'b0;
                    ifx_done <= 1'b0;
                    ify_done <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed steps plus random traffic
// against a byte-array memory model and a rule-level arbitration model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        ls_req, ls_we;
    logic [31:0] ls_addr;
    logic [2:0]  ls_size;
    logic [31:0] ls_wdata;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic        ifx_req, ify_req;
    logic [31:0] ifx_addr, ify_addr;
    logic        ifx_done, ify_done;
    logic [31:0] ifx_inst, ify_inst;
    logic        flush;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr, busy;

    int checks = 0;
    int errors = 0;

    logic [7:0]  ram     [0:4095];
    logic [7:0]  ref_mem [0:4095];
    logic        ram_ready = 1'b0;
    logic [31:0] tr_a  [$];
    logic        tr_wr [$];
    logic [7:0]  tr_d  [$];
    int          last_fetch;

    mem_arbiter #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr),
        .ls_size(ls_size), .ls_wdata(ls_wdata),
        .ls_done(ls_done), .ls_rdata(ls_rdata),
        .ifx_req(ifx_req), .ifx_addr(ifx_addr),
        .ifx_done(ifx_done), .ifx_inst(ifx_inst),
        .ify_req(ify_req), .ify_addr(ify_addr),
        .ify_done(ify_done), .ify_inst(ify_inst),
        .flush(flush), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input int i);
        logic [7:0] b;
        b = 8'(i * 29 + (i >> 4) * 7 + 3);
        if (i == 'h100) b = 8'h11;
        if (i == 'h101) b = 8'h22;
        if (i == 'h102) b = 8'h33;
        if (i == 'h103) b = 8'h44;
        return b;
    endfunction

    // RAM: combinational read of the registered address, byte write on edge.
    assign mem_din = ram[mem_a[11:0]];
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 4096; i++) ram[i] <= init_byte(i);
            ram_ready <= 1'b1;
        end else if (mem_wr) begin
            ram[mem_a[11:0]] <= mem_dout;
        end
    end

    function automatic int nbytes(input logic [2:0] s);
        return (s == 3'd1) ? 1 : (s == 3'd2) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a, input int n);
        logic [31:0] w;
        logic [31:0] ai;
        w = '0;
        for (int i = 0; i < n; i++) begin
            ai = a + 32'(i);
            w[8*i +: 8] = ref_mem[ai[11:0]];
        end
        return w;
    endfunction

    // Arbitration rule: LS first; X/Y tie goes to the one not granted last.
    function automatic int model_pick(input logic l, input logic x, input logic y);
        if (l) return 0;
        if (x && y) return (last_fetch == 1) ? 2 : 1;
        if (x) return 1;
        if (y) return 2;
        return -1;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        tr_a.push_back(mem_a);
        tr_wr.push_back(mem_wr);
        tr_d.push_back(mem_dout);
    endtask

    task automatic clr_trace();
        tr_a.delete();
        tr_wr.delete();
        tr_d.delete();
    endtask

    task automatic wait_any(input int maxc, output int who, output int lat);
        who = -1;
        lat = 0;
        for (int k = 1; k <= maxc && who < 0; k++) begin
            tick();
            if (ls_done)       begin who = 0; lat = k; end
            else if (ifx_done) begin who = 1; lat = k; end
            else if (ify_done) begin who = 2; lat = k; end
        end
    endtask

    initial begin
        int          who, lat, n, kind, seen;
        logic [31:0] a, wd, ai;
        logic [2:0]  sz;

        rst = 1'b0; rdy = 1'b1; flush = 1'b0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_size = 3'd4; ls_wdata = '0;
        ifx_req = 1'b0; ify_req = 1'b0; ifx_addr = '0; ify_addr = '0;
        last_fetch = 0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_byte(i);
        repeat (3) tick();

        check("rst_busy", busy, 0);
        check("rst_mem_a", mem_a, 0);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_mem_dout", mem_dout, 0);
        check("rst_dones", {ls_done, ifx_done, ify_done}, 0);
        check("rst_rdata", {ls_rdata, ifx_inst}, 0);
        rst = 1'b1;
        tick();

        // 4-byte load at 0x100
        ls_addr = 32'h100; ls_size = 3'd4; ls_we = 1'b0; ls_req = 1'b1;
        clr_trace();
        wait_any(20, who, lat);
        ls_req = 1'b0;
        check("ld4_who", who, 0);
        check("ld4_lat", lat, 5);
        check("ld4_data", ls_rdata, 32'h44332211);
        for (int i = 0; i < 4; i++) check("ld4_addr", tr_a[i], 32'h100 + 32'(i));
        tick();
        check("ld4_idle", busy, 0);

        // 2-byte store 0xBEEF at 0x1FE, then read back
        ls_addr = 32'h1FE; ls_size = 3'd2; ls_we = 1'b1; ls_wdata = 32'h0000BEEF;
        ls_req = 1'b1;
        clr_trace();
        wait_any(20, who, lat);
        ls_req = 1'b0;
        ref_mem[12'h1FE] = 8'hEF;
        ref_mem[12'h1FF] = 8'hBE;
        check("st2_lat", lat, 3);
        check("st2_b0", {tr_wr[0], tr_a[0], tr_d[0]}, {1'b1, 32'h1FE, 8'hEF});
        check("st2_b1", {tr_wr[1], tr_a[1], tr_d[1]}, {1'b1, 32'h1FF, 8'hBE});
        check("st2_wr_off", mem_wr, 0);
        tick();
        check("st2_done_1cyc", ls_done, 0);
        ls_we = 1'b0; ls_req = 1'b1;
        wait_any(20, who, lat);
        ls_req = 1'b0;
        check("st2_readback", ls_rdata, ref_word(32'h1FE, 2));
        tick();

        // All three request together, each drops after its done
        ls_addr = 32'h104; ls_size = 3'd4; ls_we = 1'b0;
        ifx_addr = 32'h400; ify_addr = 32'h500;
        ls_req = 1'b1; ifx_req = 1'b1; ify_req = 1'b1;
        for (int g = 0; g < 3; g++) begin
            n = model_pick(ls_req, ifx_req, ify_req);
            wait_any(20, who, lat);
            check("arb3_order", who, n);
            if (who == 0) begin
                check("arb3_ls", ls_rdata, ref_word(32'h104, 4)); ls_req = 1'b0;
            end else if (who == 1) begin
                check("arb3_x", ifx_inst, ref_word(32'h400, 4)); ifx_req = 1'b0;
                last_fetch = 1;
            end else if (who == 2) begin
                check("arb3_y", ify_inst, ref_word(32'h500, 4)); ify_req = 1'b0;
                last_fetch = 2;
            end
        end
        tick();

        // X and Y held continuously: grants alternate
        ifx_req = 1'b1; ify_req = 1'b1;
        for (int g = 0; g < 4; g++) begin
            n = model_pick(1'b0, 1'b1, 1'b1);
            wait_any(20, who, lat);
            check("rr_order", who, n);
            if (who == 1 || who == 2) last_fetch = who;
        end
        ifx_req = 1'b0; ify_req = 1'b0;
        tick();

        // Random load/store and fetch traffic
        for (int t = 0; t < 24; t++) begin
            kind = $urandom_range(0, 3);
            if (kind < 2) begin
                sz = 3'($urandom_range(0, 7));
                n = nbytes(sz);
                a = 32'h200 + 32'($urandom_range(0, 255));
                wd = $urandom;
                ls_addr = a; ls_size = sz; ls_wdata = wd; ls_we = (kind == 1);
                ls_req = 1'b1;
                clr_trace();
                wait_any(20, who, lat);
                ls_req = 1'b0;
                check("rnd_ls_who", who, 0);
                check("rnd_ls_lat", lat, n + 1);
                if (kind == 1) begin
                    for (int i = 0; i < n; i++) begin
                        ai = a + 32'(i);
                        ref_mem[ai[11:0]] = wd[8*i +: 8];
                        check("rnd_st_byte", {tr_wr[i], tr_a[i], tr_d[i]},
                              {1'b1, ai, wd[8*i +: 8]});
                    end
                end else begin
                    check("rnd_ld_data", ls_rdata, ref_word(a, n));
                end
            end else begin
                a = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
                if (kind == 2) begin ifx_addr = a; ifx_req = 1'b1; end
                else begin ify_addr = a; ify_req = 1'b1; end
                wait_any(20, who, lat);
                ifx_req = 1'b0; ify_req = 1'b0;
                check("rnd_if_who", who, kind - 1);
                check("rnd_if_lat", lat, 5);
                check("rnd_if_inst", (kind == 2) ? ifx_inst : ify_inst, ref_word(a, 4));
                last_fetch = kind - 1;
            end
            tick();
        end

        // Flush during an X fetch
        ifx_addr = 32'h40; ifx_req = 1'b1;
        clr_trace();
        tick();
        check("fl_busy", busy, 1);
        last_fetch = 1;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0; ifx_req = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ifx_done) seen++;
        end
        check("fl_no_done", seen, 0);
        for (int i = 0; i < 4; i++) check("fl_addr", tr_a[i], 32'h40 + 32'(i));
        check("fl_idle", busy, 0);
        ify_addr = 32'h80; ify_req = 1'b1;
        wait_any(20, who, lat);
        ify_req = 1'b0;
        check("fl_next_who", who, model_pick(1'b0, 1'b0, 1'b1));
        check("fl_next_lat", lat, 5);
        check("fl_next_inst", ify_inst, ref_word(32'h80, 4));
        last_fetch = 2;
        tick();

        // Fetch on the same edge as flush is not granted
        ifx_addr = 32'hC0; ifx_req = 1'b1; flush = 1'b1;
        tick();
        check("fl_idle_nogrant", busy, 0);
        flush = 1'b0;
        wait_any(20, who, lat);
        ifx_req = 1'b0;
        check("fl_idle_later", {who, lat}, {32'd1, 32'd5});
        last_fetch = 1;
        tick();

        // rdy low for 3 cycles mid-read
        ls_addr = 32'h8; ls_size = 3'd4; ls_we = 1'b0; ls_req = 1'b1;
        tick();
        tick();
        rdy = 1'b0;
        repeat (3) tick();
        check("rdy_hold_a", mem_a, 32'h9);
        rdy = 1'b1;
        wait_any(20, who, lat);
        ls_req = 1'b0;
        check("rdy_lat", (who == 0) ? lat + 5 : -1, 8);
        check("rdy_data", ls_rdata, ref_word(32'h8, 4));
        tick();

        // Reset while driving byte 1 of a write
        ls_addr = 32'h300; ls_size = 3'd4; ls_we = 1'b1; ls_wdata = 32'hA1B2C3D4;
        ls_req = 1'b1;
        tick();
        tick();
        check("wr_mid_b1", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h301, 8'hC3});
        #2;
        rst = 1'b0;
        #1;
        check("arst_outs", {mem_wr, mem_a, mem_dout, busy, ls_done}, 0);
        ref_mem[12'h300] = 8'hD4;
        ls_req = 1'b0; ls_we = 1'b0;
        last_fetch = 0;
        #1;
        rst = 1'b1;

        // After reset X is favoured; X fetch wraps the address space
        ifx_addr = 32'hFFFFFFFE; ify_addr = 32'h10;
        ifx_req = 1'b1; ify_req = 1'b1;
        clr_trace();
        wait_any(20, who, lat);
        ifx_req = 1'b0;
        check("wrap_who", who, model_pick(1'b0, 1'b1, 1'b1));
        check("wrap_a0", tr_a[0], 32'hFFFFFFFE);
        check("wrap_a1", tr_a[1], 32'hFFFFFFFF);
        check("wrap_a2", tr_a[2], 32'h0);
        check("wrap_a3", tr_a[3], 32'h1);
        check("wrap_inst", ifx_inst, ref_word(32'hFFFFFFFE, 4));
        last_fetch = 1;
        wait_any(20, who, lat);
        ify_req = 1'b0;
        check("wrap_y", {who, ify_inst}, {32'd2, ref_word(32'h10, 4)});
        tick();

        // Byte load of the partially written location
        ls_addr = 32'h300; ls_size = 3'd1; ls_req = 1'b1;
        wait_any(20, who, lat);
        ls_req = 1'b0;
        check("ld1_lat", lat, 2);
        check("ld1_data", ls_rdata, ref_word(32'h300, 1));
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
